// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: hex glyph table,
// blank pattern and the number of brightness sub-slots per digit dwell.
package seg_pkg;

    localparam int SUB_SLOTS = 16;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Active-high {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Hex nibble to active-high 7-segment pattern with decimal point and
// blanking; output polarity is left to the caller.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank) begin
            pattern = {dp, HEX_SEG[nibble][6:0]};
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment display scanner: double-buffered digit data, leading
// zero blanking, per-digit blink and 16-step PWM brightness on the digit select.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1_000,
    parameter int N_DIGITS   = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_HZ   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blink_in,
    input  logic                    lz_blank,
    input  logic [3:0]              bright,
    input  logic                    load,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     sel,
    output logic                    frame_done
);

    localparam int DWELL      = CLK_HZ / SCAN_HZ;
    localparam int SLOT_LEN   = DWELL / SUB_SLOTS;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW         = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int IW         = $clog2(N_DIGITS);
    localparam logic POL      = (ACTIVE_LOW != 0);
    localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

    // The dwell counter is kept as {slot_idx, slot_cnt} so the sub-slot
    // index is available without dividing by a non-power-of-two.
    logic [SW-1:0]           slot_cnt;
    logic [3:0]              slot_idx;
    logic [IW-1:0]           digit_idx;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_on;
    logic [3:0]              bright_q;

    logic [4*N_DIGITS-1:0]   pend_digits, disp_digits;
    logic [N_DIGITS-1:0]     pend_dp, disp_dp;
    logic [N_DIGITS-1:0]     pend_blink, disp_blink;
    logic                    pending;

    logic                    slot_end, dwell_end, dwell_start, frame_wrap;
    logic [N_DIGITS-1:0]     lead_zero;
    logic                    lz_run;
    logic [IW-1:0]           pos;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    blank_cur;
    logic [3:0]              bright_eff;
    logic [N_DIGITS-1:0]     sel_hi;
    logic [7:0]              pattern;

    assign slot_end    = (slot_cnt == SW'(SLOT_LEN - 1));
    assign dwell_end   = slot_end && (slot_idx == 4'(SUB_SLOTS - 1));
    assign dwell_start = (slot_cnt == '0) && (slot_idx == '0);
    assign frame_wrap  = dwell_end && (digit_idx == LAST);

    // lead_zero[i]: digits 0..i are all zero with no decimal point.
    always_comb begin
        lead_zero = '0;
        lz_run    = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            lz_run = lz_run && (disp_digits[4*(N_DIGITS-1-i) +: 4] == 4'h0)
                            && !disp_dp[N_DIGITS-1-i];
            lead_zero[i] = lz_run;
        end
    end

    always_comb begin
        pos        = LAST - digit_idx;
        cur_nib    = disp_digits[4*pos +: 4];
        cur_dp     = disp_dp[pos];
        blank_cur  = (lz_blank && (digit_idx != LAST) && lead_zero[digit_idx])
                   || (!blink_on && disp_blink[pos]);
        // bright is taken live on the first cycle of a dwell, then held.
        bright_eff = dwell_start ? bright : bright_q;
        sel_hi     = '0;
        if ((bright_eff == 4'd15) || (slot_idx < bright_eff)) begin
            sel_hi[pos] = 1'b1;
        end
    end

    seg_hex_decoder u_dec (
        .nibble  (cur_nib),
        .dp      (cur_dp),
        .blank   (blank_cur),
        .pattern (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt    <= '0;
            slot_idx    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            bright_q    <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_blink  <= '0;
            pending     <= 1'b0;
            disp_digits <= '0;
            disp_dp     <= '0;
            disp_blink  <= '0;
            frame_done  <= 1'b0;
            seg         <= {8{POL}};
            sel         <= {N_DIGITS{POL}};
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end) begin
                slot_idx <= slot_idx + 1'b1;
            end
            if (dwell_end) begin
                digit_idx <= (digit_idx == LAST) ? '0 : digit_idx + 1'b1;
            end
            if (dwell_start) begin
                bright_q <= bright;
            end

            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // A load landing on the wrap cycle refills pending after the
            // old contents move to the display, so it waits one more frame.
            if (frame_wrap && pending) begin
                disp_digits <= pend_digits;
                disp_dp     <= pend_dp;
                disp_blink  <= pend_blink;
            end
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_blink  <= blink_in;
                pending     <= 1'b1;
            end else if (frame_wrap) begin
                pending     <= 1'b0;
            end

            frame_done <= frame_wrap;
            seg        <= POL ? ~pattern : pattern;
            sel        <= POL ? ~sel_hi : sel_hi;
        end
    end

endmodule
